// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
// Owns the single write port of the register file. After reset it sweeps
// every address writing zero, then shares the port round-robin among
// NUM_REQ writeback requesters, one registered write per cycle.

module regfile_write_scheduler #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 16,
    parameter int INIT_CLEAR = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_write_en,
    output logic [ADDR_W-1:0]         rf_write_address,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic [1:0]                grant_idx,
    output logic                      init_done
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
    localparam logic       DONE_RST = (INIT_CLEAR != 0) ? 1'b0 : 1'b1;
    localparam logic [2:0] NREQ3    = 3'(NUM_REQ);
    localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

    // Registered state
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [1:0]        grant_q, grant_d;
    logic              init_done_q, init_done_d;

    // Arbitration results
    logic [3:0]        valid4_s;
    logic              found_s;
    logic [1:0]        gnt_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [NUM_REQ-1:0] ready_s;

    // Round-robin search from rr_ptr, wrapping modulo NUM_REQ; ready only in RUN
    always_comb begin
        logic [2:0] sum_v;
        logic [2:0] cand_v;
        logic       hit_v;
        valid4_s   = 4'(req_valid);
        found_s    = 1'b0;
        gnt_s      = 2'd0;
        sel_addr_s = {ADDR_W{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        ready_s    = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v  = {1'b0, rr_ptr_q} + 3'(k);
            cand_v = (sum_v >= NREQ3) ? (sum_v - NREQ3) : sum_v;
            hit_v  = !found_s && valid4_s[cand_v[1:0]];
            gnt_s  = hit_v ? cand_v[1:0] : gnt_s;
            found_s = found_s | hit_v;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s = (gnt_s == 2'(i)) ? req_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
            sel_data_s = (gnt_s == 2'(i)) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
            ready_s[i] = (state_q == ST_RUN) && found_s && (gnt_s == 2'(i));
        end
    end

    assign req_ready = ready_s;

    // Next-state logic: clear sweep in INIT, granted write in RUN
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grant_d     = grant_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = {DATA_W{1'b0}};
                clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                init_done_d = 1'b1;
                if (found_s) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = sel_addr_s;
                    wr_data_d = sel_data_s;
                    grant_d   = gnt_s;
                    rr_ptr_d  = (gnt_s == LAST_IDX) ? 2'd0 : (gnt_s + 2'd1);
                end else begin
                    wr_en_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            clr_cnt_q   <= {ADDR_W{1'b0}};
            rr_ptr_q    <= 2'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= {DATA_W{1'b0}};
            grant_q     <= 2'd0;
            init_done_q <= DONE_RST;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            grant_q     <= grant_d;
            init_done_q <= init_done_d;
        end
    end

    assign rf_write_en      = wr_en_q;
    assign rf_write_address = wr_addr_q;
    assign rf_write_data    = wr_data_q;
    assign grant_idx        = grant_q;
    assign init_done        = init_done_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: clear sweep, table of RUN-mode vectors,
// and hand-written reset-in-the-middle sequences.

module tb_regfile_write_scheduler;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic        rf_write_en;
    logic [3:0]  rf_write_address;
    logic [15:0] rf_write_data;
    logic [1:0]  grant_idx;
    logic        init_done;

    int n_total;
    int n_pass;

    typedef struct {
        logic [2:0]  valid;
        logic [11:0] addr;
        logic [47:0] data;
        logic [2:0]  exp_ready;
        logic        exp_wen;
        logic [3:0]  exp_addr;
        logic [15:0] exp_data;
        logic [1:0]  exp_gnt;
    } vec_t;

    vec_t vecs[17];

    regfile_write_scheduler #(
        .NUM_REQ(3), .ADDR_W(4), .DATA_W(16), .INIT_CLEAR(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_write_en(rf_write_en), .rf_write_address(rf_write_address),
        .rf_write_data(rf_write_data), .grant_idx(grant_idx),
        .init_done(init_done)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] v,
                                input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                                input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                                input logic [2:0] rdy, input logic wen, input logic [3:0] wa,
                                input logic [15:0] wd, input logic [1:0] g);
        vec_t r;
        r.valid = v;
        r.addr = {a2, a1, a0};
        r.data = {d2, d1, d0};
        r.exp_ready = rdy;
        r.exp_wen = wen;
        r.exp_addr = wa;
        r.exp_data = wd;
        r.exp_gnt = g;
        return r;
    endfunction

    // Clear sweep from reset release: addresses 0..15 on edges 1..16
    task automatic sweep(input logic [2:0] exp_ready_last);
        for (int e = 1; e <= 16; e++) begin
            step();
            chk("sweep_wen", 64'(rf_write_en), 64'd1);
            chk("sweep_addr", 64'(rf_write_address), 64'(e - 1));
            chk("sweep_data", 64'(rf_write_data), 64'd0);
            chk("sweep_init_done", 64'(init_done), 64'd0);
            if (e < 16) begin
                chk("sweep_ready", 64'(req_ready), 64'd0);
            end else begin
                chk("ready_after_sweep", 64'(req_ready), 64'(exp_ready_last));
            end
        end
    endtask

    initial begin
        n_total = 0;
        n_pass = 0;

        // rr_ptr is 1 on entry: it was 0 after reset and edge 17 granted req0
        vecs[0]  = mk(3'b010, 4'h0, 4'h5, 4'h0, 16'h0000, 16'hBEEF, 16'h0000, 3'b010, 1'b1, 4'h5, 16'hBEEF, 2'd1);
        vecs[1]  = mk(3'b000, 4'h0, 4'h5, 4'h0, 16'h0000, 16'hBEEF, 16'h0000, 3'b000, 1'b0, 4'h5, 16'hBEEF, 2'd1);
        vecs[2]  = mk(3'b100, 4'h0, 4'h0, 4'h9, 16'h0000, 16'h0000, 16'h2222, 3'b100, 1'b1, 4'h9, 16'h2222, 2'd2);
        vecs[3]  = mk(3'b111, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b001, 1'b1, 4'hA, 16'hA0A0, 2'd0);
        vecs[4]  = mk(3'b111, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b010, 1'b1, 4'hB, 16'hB1B1, 2'd1);
        vecs[5]  = mk(3'b111, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b100, 1'b1, 4'hC, 16'hC2C2, 2'd2);
        vecs[6]  = mk(3'b111, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b001, 1'b1, 4'hA, 16'hA0A0, 2'd0);
        vecs[7]  = mk(3'b111, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b010, 1'b1, 4'hB, 16'hB1B1, 2'd1);
        vecs[8]  = mk(3'b111, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b100, 1'b1, 4'hC, 16'hC2C2, 2'd2);
        // pointer skip: set rr_ptr=1, then req0+req2 valid -> 2 then 0
        vecs[9]  = mk(3'b001, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b001, 1'b1, 4'hA, 16'hA0A0, 2'd0);
        vecs[10] = mk(3'b101, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b100, 1'b1, 4'hC, 16'hC2C2, 2'd2);
        vecs[11] = mk(3'b101, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b001, 1'b1, 4'hA, 16'hA0A0, 2'd0);
        // rr_ptr must now be 1: req0+req1 valid grants req1
        vecs[12] = mk(3'b011, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b010, 1'b1, 4'hB, 16'hB1B1, 2'd1);
        vecs[13] = mk(3'b100, 4'hA, 4'hB, 4'hC, 16'hA0A0, 16'hB1B1, 16'hC2C2, 3'b100, 1'b1, 4'hC, 16'hC2C2, 2'd2);
        // withdrawn request: req2 (addr 7, DEAD) waits behind req0, then drops
        vecs[14] = mk(3'b101, 4'hA, 4'hB, 4'h7, 16'hA0A0, 16'hB1B1, 16'hDEAD, 3'b001, 1'b1, 4'hA, 16'hA0A0, 2'd0);
        vecs[15] = mk(3'b000, 4'hA, 4'hB, 4'h7, 16'hA0A0, 16'hB1B1, 16'hDEAD, 3'b000, 1'b0, 4'hA, 16'hA0A0, 2'd0);
        // same address as the previous write: forwarded again in order
        vecs[16] = mk(3'b010, 4'hA, 4'hA, 4'h7, 16'hA0A0, 16'h5151, 16'hDEAD, 3'b010, 1'b1, 4'hA, 16'h5151, 2'd1);

        // Reset with all requesters valid
        rst_n = 1'b0;
        req_valid = 3'b111;
        req_addr = {4'h3, 4'h2, 4'h1};
        req_data = {16'h3333, 16'h2222, 16'h1111};
        step();
        step();
        chk("rst_wen", 64'(rf_write_en), 64'd0);
        chk("rst_addr", 64'(rf_write_address), 64'd0);
        chk("rst_data", 64'(rf_write_data), 64'd0);
        chk("rst_gnt", 64'(grant_idx), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;

        sweep(3'b001);
        step();
        chk("first_grant_wen", 64'(rf_write_en), 64'd1);
        chk("first_grant_idx", 64'(grant_idx), 64'd0);
        chk("first_grant_addr", 64'(rf_write_address), 64'h1);
        chk("first_grant_data", 64'(rf_write_data), 64'h1111);
        chk("init_done_edge17", 64'(init_done), 64'd1);

        // Table-driven RUN vectors
        for (int i = 0; i < 17; i++) begin
            req_valid = vecs[i].valid;
            req_addr = vecs[i].addr;
            req_data = vecs[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            step();
            chk($sformatf("v%0d_wen", i), 64'(rf_write_en), 64'(vecs[i].exp_wen));
            chk($sformatf("v%0d_addr", i), 64'(rf_write_address), 64'(vecs[i].exp_addr));
            chk($sformatf("v%0d_data", i), 64'(rf_write_data), 64'(vecs[i].exp_data));
            chk($sformatf("v%0d_gnt", i), 64'(grant_idx), 64'(vecs[i].exp_gnt));
        end

        // Reset during the sweep at clr_cnt=7 restarts at address 0
        req_valid = 3'b000;
        rst_n = 1'b0;
        step();
        chk("rst2_wen", 64'(rf_write_en), 64'd0);
        chk("rst2_init_done", 64'(init_done), 64'd0);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("part_sweep_addr", 64'(rf_write_address), 64'(e - 1));
        end
        rst_n = 1'b0;
        step();
        chk("mid_sweep_rst_wen", 64'(rf_write_en), 64'd0);
        chk("mid_sweep_rst_addr", 64'(rf_write_address), 64'd0);
        rst_n = 1'b1;
        req_valid = 3'b001;
        req_addr = {4'h0, 4'h0, 4'h3};
        req_data = {16'h0000, 16'h0000, 16'h3333};
        sweep(3'b001);

        // Handshake with req0, then reset on the following edge drops it
        step();
        chk("hs_wen", 64'(rf_write_en), 64'd1);
        chk("hs_addr", 64'(rf_write_address), 64'h3);
        chk("hs_data", 64'(rf_write_data), 64'h3333);
        rst_n = 1'b0;
        req_valid = 3'b000;
        step();
        chk("drop_wen", 64'(rf_write_en), 64'd0);
        chk("drop_addr", 64'(rf_write_address), 64'd0);
        chk("drop_data", 64'(rf_write_data), 64'd0);
        chk("drop_init_done", 64'(init_done), 64'd0);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
